// File: rtl/source_byte_packer.sv
// rtl/source_byte_packer.sv - packs an MSB-first byte stream into SRC_WIDTH-bit source words
module source_byte_packer #(
    parameter int SRC_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic [SRC_WIDTH-1:0] src,
    output logic                 busy
);
    localparam int NB    = (SRC_WIDTH + 7) / 8;
    localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int ASM_W = (NB > 1) ? (NB - 1) * 8 : 8;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SRC_WIDTH-1:0] src_q, src_d;
    logic                 src_valid_q, src_valid_d;
    logic [SRC_WIDTH-1:0] word;
    logic                 accept;
    logic                 last_byte;

    assign last_byte = (cnt_q == LAST);
    // Only the final byte needs a free output slot; earlier bytes go into asm.
    assign in_ready  = !flush && !(last_byte && src_valid_q && !src_ready);
    assign accept    = in_valid && in_ready;

    generate
        if (NB > 1) begin : g_asm
            logic [ASM_W-1:0] asm_q, asm_d;

            always_comb begin
                asm_d = asm_q;
                if (accept && !last_byte) begin
                    asm_d = (asm_q << 8) | ASM_W'(in_data);
                end
            end

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    asm_q <= '0;
                end else begin
                    asm_q <= asm_d;
                end
            end

            // Truncation drops the PAD top bits of the first byte.
            assign word = SRC_WIDTH'({asm_q, in_data});
        end else begin : g_no_asm
            assign word = SRC_WIDTH'(in_data);
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q;
        src_d       = src_q;
        src_valid_d = src_valid_q;
        if (src_valid_q && src_ready) begin
            src_valid_d = 1'b0;
        end
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            if (last_byte) begin
                src_d       = word;
                src_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q       <= '0;
            src_q       <= '0;
            src_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            src_valid_q <= src_valid_d;
        end
    end

    assign src       = src_q;
    assign src_valid = src_valid_q;
    assign busy      = (cnt_q != '0);
endmodule
